// File: rtl/dm_stack_mem_if.sv
// dm_stack_mem_if -- request/response bundle for the stack-aware data memory.
//
// Signals:
//   addr, wdata                 word address and write data for store/load/push
//   store, load, push, pop      operation requests; at most one per cycle
//   clr_err                     clears the sticky error flags
//   rdata, rd_valid             registered read data and its one-cycle strobe
//   sp, depth, empty, full      stack status
//   ovf, unf, cmd_err           sticky error flags
//
// The master modport belongs to the datapath that issues requests.
// The slave modport belongs to the memory.
interface dm_stack_mem_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 9,
    parameter int DEPTH_W = 7
);
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               store;
    logic               load;
    logic               push;
    logic               pop;
    logic               clr_err;
    logic [DATA_W-1:0]  rdata;
    logic               rd_valid;
    logic [ADDR_W-1:0]  sp;
    logic [DEPTH_W-1:0] depth;
    logic               empty;
    logic               full;
    logic               ovf;
    logic               unf;
    logic               cmd_err;

    modport master (
        output addr, wdata, store, load, push, pop, clr_err,
        input  rdata, rd_valid, sp, depth, empty, full, ovf, unf, cmd_err
    );

    modport slave (
        input  addr, wdata, store, load, push, pop, clr_err,
        output rdata, rd_valid, sp, depth, empty, full, ovf, unf, cmd_err
    );
endinterface

// File: rtl/dm_stack_mem.sv
// dm_stack_mem -- single-port data memory with an internal, bounds-checked
// downward-growing stack.
//
// The block owns the stack pointer. It accepts one operation per cycle:
//   store  mem[addr] <= wdata
//   load   rdata <= mem[addr], with rd_valid asserted on the next cycle
//   push   mem[sp] <= wdata, then depth+1
//   pop    depth-1, then rdata <= top word, with rd_valid asserted on the next cycle
//
// When the stack is full, a push is rejected and ovf is set.
// When the stack is empty, a pop is rejected and unf is set.
// If more than one operation is requested in the same cycle, none of them
// is performed and cmd_err is set.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; it clears the registers but not
//          the memory array
//   bus    dm_stack_mem_if slave modport; see the interface file for the
//          list of signals
module dm_stack_mem #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 9,
    parameter int STACK_DEPTH = 64,
    parameter int STACK_TOP   = (1 << ADDR_W) - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    dm_stack_mem_if.slave bus
);

    localparam int WORDS   = 1 << ADDR_W;
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    if (STACK_DEPTH < 1 || STACK_DEPTH > WORDS) begin : g_bad_depth
        $error("dm_stack_mem: STACK_DEPTH must be in 1..2**ADDR_W");
    end
    if (STACK_TOP < 0 || STACK_TOP >= WORDS) begin : g_bad_top
        $error("dm_stack_mem: STACK_TOP must be a valid word address");
    end
    if (STACK_DEPTH > STACK_TOP + 1) begin : g_stack_wraps
        $error("dm_stack_mem: STACK_DEPTH exceeds STACK_TOP+1, stack would wrap below 0");
    end

    logic [DATA_W-1:0]  mem [WORDS];

    logic [DEPTH_W-1:0] depth_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               rd_valid_q;
    logic               ovf_q;
    logic               unf_q;
    logic               cmd_err_q;

    logic [2:0]         n_req;
    logic               conflict;
    logic               st_ok;
    logic               ld_ok;
    logic               push_ok;
    logic               pop_ok;
    logic               push_rej;
    logic               pop_rej;
    logic               empty;
    logic               full;
    logic [ADDR_W-1:0]  sp;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  wr_addr;
    logic               wr_en;

    always_comb begin
        empty    = (depth_q == '0);
        full     = (depth_q == DEPTH_W'(STACK_DEPTH));
        // Wraps modulo 2**ADDR_W by construction of the width.
        sp       = ADDR_W'(STACK_TOP) - ADDR_W'(depth_q);

        n_req    = 3'(bus.store) + 3'(bus.load) + 3'(bus.push) + 3'(bus.pop);
        conflict = (n_req > 3'd1);

        st_ok    = bus.store & ~conflict;
        ld_ok    = bus.load  & ~conflict;
        push_ok  = bus.push  & ~conflict & ~full;
        pop_ok   = bus.pop   & ~conflict & ~empty;
        push_rej = bus.push  & ~conflict &  full;
        pop_rej  = bus.pop   & ~conflict &  empty;

        // The top of the stack sits one slot above the next free slot.
        rd_addr  = pop_ok  ? sp + ADDR_W'(1) : bus.addr;
        wr_addr  = push_ok ? sp : bus.addr;
        // Reset blocks any write requested in the same cycle.
        wr_en    = rst_n & (st_ok | push_ok);
    end

    // The memory array has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            // The array read sees the contents from before the edge. A write
            // issued on the previous edge is therefore already visible here.
            if (ld_ok || pop_ok) begin
                rdata_q <= mem[rd_addr];
            end
            rd_valid_q <= ld_ok | pop_ok;

            if (push_ok) begin
                depth_q <= depth_q + DEPTH_W'(1);
            end else if (pop_ok) begin
                depth_q <= depth_q - DEPTH_W'(1);
            end

            // When clr_err and a new error occur in the same cycle,
            // the new error wins.
            ovf_q     <= (ovf_q     & ~bus.clr_err) | push_rej;
            unf_q     <= (unf_q     & ~bus.clr_err) | pop_rej;
            cmd_err_q <= (cmd_err_q & ~bus.clr_err) | conflict;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.sp       = sp;
    assign bus.depth    = depth_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
    assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_dm_stack_mem.sv
module tb_dm_stack_mem;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 9;
    localparam int SDEPTH  = 64;
    localparam int DEPTH_W = 7;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_q [$];

    dm_stack_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) bus ();

    dm_stack_mem #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STACK_DEPTH(SDEPTH), .STACK_TOP(511)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        bus.store   = 1'b0;
        bus.load    = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    // Advances one clock. If a read is expected, its data is queued first.
    // After the edge, the expected read (if any) is popped and compared.
    task automatic tick(input bit exp_rd, input logic [DATA_W-1:0] exp_d);
        logic [DATA_W-1:0] e;
        if (exp_rd) exp_q.push_back(exp_d);
        @(posedge clk);
        #1;
        clear_req();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_valid", 32'(bus.rd_valid), 32'd1);
            chk("rdata", 32'(bus.rdata), 32'(e));
        end else begin
            chk("rd_valid_low", 32'(bus.rd_valid), 32'd0);
        end
    endtask

    task automatic do_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.addr = a; bus.wdata = d; bus.store = 1'b1;
        tick(1'b0, '0);
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        bus.addr = a; bus.load = 1'b1;
        tick(1'b1, e);
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d);
        bus.wdata = d; bus.push = 1'b1;
        tick(1'b0, '0);
    endtask

    task automatic do_pop(input bit ok, input logic [DATA_W-1:0] e);
        bus.pop = 1'b1;
        tick(ok, e);
    endtask

    task automatic do_idle();
        tick(1'b0, '0);
    endtask

    task automatic chk_flags(input string tag, input logic o, input logic u, input logic c);
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(o));
        chk({tag, "_unf"}, 32'(bus.unf), 32'(u));
        chk({tag, "_cmd_err"}, 32'(bus.cmd_err), 32'(c));
    endtask

    initial begin
        clear_req();
        bus.addr  = '0;
        bus.wdata = '0;
        rst_n     = 1'b0;

        // Initial reset.
        do_idle();
        do_idle();
        rst_n = 1'b1;
        chk("rst_sp", 32'(bus.sp), 32'h1FF);
        chk("rst_depth", 32'(bus.depth), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);

        // Reset must override a push: no write, no depth change.
        do_store(9'h1FF, 16'h5A5A);
        rst_n = 1'b0;
        bus.wdata = 16'hDEAD; bus.push = 1'b1;
        tick(1'b0, '0);
        bus.wdata = 16'hDEAD; bus.push = 1'b1;
        tick(1'b0, '0);
        rst_n = 1'b1;
        chk("rstpush_depth", 32'(bus.depth), 32'd0);
        chk("rstpush_sp", 32'(bus.sp), 32'h1FF);
        chk("rstpush_empty", 32'(bus.empty), 32'd1);
        do_load(9'h1FF, 16'h5A5A);

        // Store followed by load of the same address.
        do_store(9'h010, 16'hBEEF);
        do_load(9'h010, 16'hBEEF);
        do_idle();
        chk("idle_hold_rdata", 32'(bus.rdata), 32'hBEEF);

        // LIFO ordering.
        do_push(16'h1111);
        do_push(16'h2222);
        do_push(16'h3333);
        chk("lifo_sp", 32'(bus.sp), 32'h1FC);
        chk("lifo_depth", 32'(bus.depth), 32'd3);
        chk("lifo_empty", 32'(bus.empty), 32'd0);
        do_pop(1'b1, 16'h3333);
        do_pop(1'b1, 16'h2222);
        do_pop(1'b1, 16'h1111);
        chk("lifo_empty_after", 32'(bus.empty), 32'd1);

        // Underflow: pop while the stack is empty.
        do_pop(1'b0, '0);
        chk_flags("unf", 1'b0, 1'b1, 1'b0);
        chk("unf_sp", 32'(bus.sp), 32'h1FF);
        chk("unf_rdata_hold", 32'(bus.rdata), 32'h1111);

        // Overflow. 0x1BF is the slot a 65th push would write to.
        do_store(9'h1BF, 16'h7777);
        for (int i = 0; i < SDEPTH; i++) begin
            do_push(16'(16'h0100 + i));
            if (i == SDEPTH - 2) chk("almost_full", 32'(bus.full), 32'd0);
        end
        chk("full", 32'(bus.full), 32'd1);
        chk("full_depth", 32'(bus.depth), 32'd64);
        chk("full_sp", 32'(bus.sp), 32'h1BF);
        do_push(16'hFFFF);
        chk_flags("ovf", 1'b1, 1'b1, 1'b0);
        chk("ovf_depth", 32'(bus.depth), 32'd64);
        do_load(9'h1BF, 16'h7777);
        bus.clr_err = 1'b1;
        do_idle();
        chk_flags("clr", 1'b0, 1'b0, 1'b0);
        do_pop(1'b1, 16'h013F);
        chk("pop_full_depth", 32'(bus.depth), 32'd63);

        // Conflict: push and load together must do nothing.
        bus.wdata = 16'hAAAA; bus.push = 1'b1; bus.load = 1'b1; bus.addr = 9'h1BF;
        tick(1'b0, '0);
        chk_flags("conf", 1'b0, 1'b0, 1'b1);
        chk("conf_depth", 32'(bus.depth), 32'd63);
        do_load(9'h1C0, 16'h013F);
        do_load(9'h1BF, 16'h7777);
        // A new conflict in the same cycle as clr_err keeps cmd_err set.
        bus.clr_err = 1'b1; bus.push = 1'b1; bus.pop = 1'b1;
        tick(1'b0, '0);
        chk("conf_set_wins", 32'(bus.cmd_err), 32'd1);
        chk("conf2_depth", 32'(bus.depth), 32'd63);
        bus.clr_err = 1'b1;
        do_idle();
        chk("conf_cleared", 32'(bus.cmd_err), 32'd0);

        // Reset in the middle of a stack operation.
        rst_n = 1'b0;
        do_idle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) do_push(16'(16'h0A00 + i));
        chk("mid_depth5", 32'(bus.depth), 32'd5);
        do_load(9'h1FB, 16'h0A04);
        rst_n = 1'b0;
        do_pop(1'b0, '0);
        rst_n = 1'b1;
        chk("mid_depth", 32'(bus.depth), 32'd0);
        chk("mid_rdata", 32'(bus.rdata), 32'd0);
        chk("mid_sp", 32'(bus.sp), 32'h1FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
